// File: rtl/seq_div_if.sv
// seq_div_if
//   Groups the start/done handshake, operands and results of seq_div.
//   Clock and reset are not part of the interface; they stay plain ports.
//
//   start        requester -> divider  request pulse, accepted only when idle
//   a, b         requester -> divider  dividend / divisor, unsigned
//   busy         divider -> requester  high while iterating
//   done         divider -> requester  one-cycle completion pulse
//   quot, rem    divider -> requester  registered quotient / remainder
//   div_by_zero  divider -> requester  last accepted operation had b == 0
interface seq_div_if #(
  parameter int DATAWIDTH = 8
);
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 div_by_zero;

  // Requester side (testbench or upstream control).
  modport master (
    output start, a, b,
    input  busy, done, quot, rem, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// seq_div
//   Iterative unsigned restoring divider, one quotient bit per clock.
//   A request accepted in IDLE with b != 0 spends DATAWIDTH cycles in CALC,
//   then pulses done for one cycle in DONE. A request with b == 0 goes
//   straight to DONE with quot = all ones, rem = a, div_by_zero = 1.
//   quot/rem/div_by_zero only change on the edge that enters DONE, so a
//   downstream register may capture them on any later edge using done.
//
//   Clk   in   clock, rising edge active
//   Rst   in   synchronous active-high reset
//   bus   slave modport of seq_div_if (start, a, b -> busy, done, quot,
//              rem, div_by_zero); every output is a register.
module seq_div #(
  parameter int DATAWIDTH = 8
) (
  input  logic      Clk,
  input  logic      Rst,
  seq_div_if.slave  bus
);

  localparam int CNT_W = $clog2(DATAWIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Control and visible result registers (reset).
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  // Working datapath registers (no reset; only meaningful inside CALC).
  // dvd_q shifts the dividend out of its MSB while quotient bits enter at
  // its LSB, so after DATAWIDTH steps it holds the quotient.
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH:0]   prem_q, prem_d;

  // One restoring step.
  logic [DATAWIDTH:0]   shifted;
  logic [DATAWIDTH:0]   trial;
  logic                 qbit;
  logic [DATAWIDTH:0]   prem_nxt;
  logic [DATAWIDTH-1:0] dvd_nxt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    prem_d   = prem_q;

    shifted  = (prem_q << 1) | {{DATAWIDTH{1'b0}}, dvd_q[DATAWIDTH-1]};
    // The partial remainder is always < divisor, so shifted < 2*divisor and
    // the difference fits in DATAWIDTH+1 bits as a two's-complement value:
    // its MSB is the borrow/negative flag.
    trial    = shifted - {1'b0, dvs_q};
    qbit     = ~trial[DATAWIDTH];
    prem_nxt = qbit ? trial : shifted;
    dvd_nxt  = {dvd_q[DATAWIDTH-2:0], qbit};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.b != '0) begin
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            prem_d  = '0;
            cnt_d   = CNT_W'(DATAWIDTH);
            state_d = S_CALC;
          end else begin
            quot_d  = '1;
            rem_d   = bus.a;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        dvd_d  = dvd_nxt;
        prem_d = prem_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = dvd_nxt;
          rem_d   = prem_nxt[DATAWIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags are registered from the next state so they align with it.
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // Control / result registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge Clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    prem_q <= prem_d;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div
//   Directed bench for seq_div with DATAWIDTH = 8. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
module tb_seq_div;

  logic Clk;
  logic Rst;
  int   vectors;
  int   miscompares;

  seq_div_if #(.DATAWIDTH(8)) bus ();

  seq_div #(.DATAWIDTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eb, input logic ed,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
    chk({tag, ".busy"}, 8'(bus.busy), 8'(eb));
    chk({tag, ".done"}, 8'(bus.done), 8'(ed));
    chk({tag, ".quot"}, bus.quot, eq);
    chk({tag, ".rem"},  bus.rem,  er);
    chk({tag, ".dbz"},  8'(bus.div_by_zero), 8'(ez));
  endtask

  // Pulse start at the next edge (edge N), scramble a/b afterwards, then
  // walk through CALC (if b != 0) and DONE, checking every cycle.
  task automatic do_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = bv + 8'd1;
    if (bv != 8'd0) begin
      for (int k = 0; k < 8; k++) begin
        chk({tag, ".calc_busy"}, 8'(bus.busy), 8'd1);
        chk({tag, ".calc_done"}, 8'(bus.done), 8'd0);
        tick();
      end
    end
    chk_out({tag, ".done"}, 1'b0, 1'b1, eq, er, ez);
    tick();
    chk_out({tag, ".hold"}, 1'b0, 1'b0, eq, er, ez);
    tick();
    chk_out({tag, ".hold2"}, 1'b0, 1'b0, eq, er, ez);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = 8'd0;
    bus.b       = 8'd0;

    // Reset then idle
    tick();
    tick();
    Rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("idle", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    end

    // Basic division and boundary operands
    do_div("100/7",   8'd100, 8'd7,   8'd14,  8'd2,  1'b0);
    do_div("255/1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    do_div("5/9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
    do_div("0/3",     8'd0,   8'd3,   8'd0,   8'd0,  1'b0);
    do_div("255/255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0);

    // Divide by zero, then a normal division clears the flag
    do_div("42/0",    8'd42,  8'd0,   8'd255, 8'd42, 1'b1);
    do_div("9/3",     8'd9,   8'd3,   8'd3,   8'd0,  1'b0);

    // Start while busy: 200/3 accepted at edge N, 10/2 offered at N+3, N+9
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd3;
    tick();                          // after N
    bus.start = 1'b0;
    tick();
    tick();                          // after N+2
    bus.start = 1'b1;
    bus.a     = 8'd10;
    bus.b     = 8'd2;
    tick();                          // after N+3
    bus.start = 1'b0;
    chk_out("busy_ign.n3", 1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();   // after N+7
    chk_out("busy_ign.n7", 1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
    tick();                          // after N+8
    chk_out("busy_ign.done", 1'b0, 1'b1, 8'd66, 8'd2, 1'b0);
    bus.start = 1'b1;
    tick();                          // after N+9: start seen in DONE, ignored
    bus.start = 1'b0;
    chk_out("busy_ign.n9", 1'b0, 1'b0, 8'd66, 8'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("busy_ign.after", 1'b0, 1'b0, 8'd66, 8'd2, 1'b0);
    end

    // Reset mid-operation: 77/5 accepted at N, Rst at edge N+4
    bus.start = 1'b1;
    bus.a     = 8'd77;
    bus.b     = 8'd5;
    tick();                          // after N
    bus.start = 1'b0;
    tick();
    tick();
    tick();                          // after N+3
    Rst = 1'b1;
    tick();                          // after N+4
    Rst = 1'b0;
    chk_out("midrst", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("midrst.quiet", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    end
    do_div("77/5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Iterative unsigned divider for the datapath component library, with a start/done handshake. It takes one quotient bit per clock, so its logic cost does not grow like a combinational divider's. It sits directly upstream of a REG stage. The quot and rem outputs are held stable after completion, so the downstream REG can capture them on any later edge, using done as the load qualifier.

## Interface

Parameters:
- DATAWIDTH, default 8: width of the operands, quotient and remainder. Legal range is 2 to 64.

Ports:
- Clk  input  1  the single clock; all state changes on the rising edge.
- Rst  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- start  input  1  request pulse; accepted only in IDLE.
- a  input  DATAWIDTH  dividend, unsigned; sampled when start is accepted.
- b  input  DATAWIDTH  divisor, unsigned; sampled when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; high only in the DONE state.
- quot  output  DATAWIDTH  quotient, registered.
- rem  output  DATAWIDTH  remainder, registered.
- div_by_zero  output  1  set when b was 0 for the last accepted operation; registered.

## Operation

- States: IDLE, CALC, DONE. Encoding is free.
- IDLE:
  - On start=1 with b≠0: latch a into a shift register and b into a divisor register. Clear the partial remainder (DATAWIDTH+1 bits). Set the iteration counter to DATAWIDTH. Go to CALC.
  - On start=1 with b=0: go straight to DONE with quot = all ones, rem = a, div_by_zero = 1.
  - On start=0: stay in IDLE.
- CALC, one restoring step per cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor in DATAWIDTH+1 bits.
  - If the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - Decrement the counter.
  - On the step where the counter reaches 0: load quot and rem from the working registers, clear div_by_zero, and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in CALC and DONE; there is no queuing. A start held high through DONE is accepted on the first IDLE edge.
- a and b may change freely after acceptance without affecting the result in flight.
- quot, rem and div_by_zero change only on the edge that enters DONE, and otherwise hold their value indefinitely.
- Arithmetic is unsigned only; the working remainder is one bit wider than DATAWIDTH to avoid trial-subtraction overflow. For b≠0, results satisfy a = quot·b + rem with rem < b.

## Timing

- Reset (Rst=1 at an edge), from any state: go to IDLE. busy=0, done=0, quot=0, rem=0, div_by_zero=0, counter=0.
  - Reset has priority over start.
  - A division in flight is discarded, and no done pulse is produced for it.
- start accepted at edge N with b≠0:
  - busy is high after edges N through N+DATAWIDTH−1.
  - The result loads at edge N+DATAWIDTH.
  - done is high in the cycle after edge N+DATAWIDTH, i.e. it is sampled high by the downstream stage at edge N+DATAWIDTH+1.
  - Latency is DATAWIDTH+1 edges from acceptance to done being sampled.
- start accepted at edge N with b=0: the result loads at edge N, and done is high in the cycle after edge N; busy stays 0.
- Throughput:
  - b≠0: one operation every DATAWIDTH+2 cycles with start held high.
  - b=0: one operation every 2 cycles with start held high.
- All outputs are driven by registers; there is no combinational path from inputs to outputs.

## Test plan

All scenarios use DATAWIDTH=8.

- Reset then idle: Rst high for 2 cycles, then start=0 for 20 cycles -> all outputs stay 0; busy and done never assert.
- Basic division: a=100, b=7, start pulsed at edge N -> busy high for 8 cycles; done sampled high only at edge N+9; quot=14, rem=2, div_by_zero=0; all three hold after done drops.
- Boundary operands:
  - a=255, b=1 -> quot=255, rem=0.
  - a=5, b=9 -> quot=0, rem=5.
  - a=0, b=3 -> quot=0, rem=0.
  - a=255, b=255 -> quot=1, rem=0.
- Divide by zero: a=42, b=0, start at edge N -> busy stays 0; done sampled high at edge N+1; quot=255, rem=42, div_by_zero=1. A following 9/3 must then give quot=3, rem=0, div_by_zero=0.
- Start while busy: start a=200, b=3, then pulse start with a=10, b=2 at edges N+3 and N+9 -> second request ignored; a single done pulse; quot=66, rem=2. Changing a and b mid-CALC has no effect on the result.
- Reset mid-operation: start a=77, b=5, assert Rst at edge N+4 -> outputs 0 at N+4; no done pulse follows. A fresh start of 77/5 then completes normally with quot=15, rem=2.
